i2s_unit: RTL and testbench
===========================

I2S_UNIT -- requirements
Module: i2s_unit

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all flip-flops are clocked on its rising edge.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port play_in, input, 1 bit: streaming enable, level-sensitive.
REQ-004 The module SHALL have the port tick_in, input, 1 bit: one-cycle pulse marking audio0_in and audio1_in as valid.
REQ-005 The module SHALL have the port audio0_in, input, 24 bits: left sample, two's complement.
REQ-006 The module SHALL have the port audio1_in, input, 24 bits: right sample, two's complement.
REQ-007 The module SHALL have the port req_out, output, 1 bit: one-cycle request for the next sample pair.
REQ-008 The module SHALL have the port sck_out, output, 1 bit: I2S serial clock.
REQ-009 The module SHALL have the port ws_out, output, 1 bit: I2S word select (0 = left, 1 = right).
REQ-010 The module SHALL have the port sdo_out, output, 1 bit: I2S serial data, MSB first.

Function
REQ-011 The module SHALL define constants H = I2S_HALF_PERIOD = 4 clk cycles and the frame = 48 slots × 2H = 384 clk cycles; frame cycle index c runs 0..383 and slot s = c / (2H).
REQ-012 The module SHALL implement two states: IDLE and RUN.
REQ-013 In IDLE, sck_out, ws_out, sdo_out and req_out SHALL be 0.
REQ-014 In IDLE with play_in=1, the module SHALL move to RUN on the next clock edge, and that first RUN cycle SHALL be c=0.
REQ-015 A 48-bit input register SHALL capture {audio0_in, audio1_in} on every clk edge where tick_in=1, in any state.
REQ-016 At c=0, the 48-bit shift register SHALL load from the input register, and req_out SHALL be 1 for exactly that cycle.
REQ-017 If tick_in=1 in the same cycle as the c=0 load, the load SHALL use the old input register value, and the new sample SHALL be used in the next frame.
REQ-018 If no tick_in arrives between loads, the previous sample pair SHALL be retransmitted.
REQ-019 In RUN, sck_out SHALL be 1 when (c mod 2H) ≥ H and 0 otherwise, so each slot starts with sck_out low and data changes on the falling edge.
REQ-020 In RUN, sdo_out in slot s SHALL be bit (47−s) of the shift register: slots 0..23 carry audio0[23:0] and slots 24..47 carry audio1[23:0].
REQ-021 In RUN, ws_out SHALL be 1 in slots 23..46 and 0 in slots 47 and 0..22, so WS leads each channel MSB by one slot.
REQ-022 All outputs SHALL be driven from registers or decoded state only, with no combinational path from any input to any output.
REQ-023 play_in SHALL be sampled only at c=383: if 1, the next cycle SHALL be c=0 of a new frame; if 0, the next state SHALL be IDLE.
REQ-024 Deasserting play_in mid-frame SHALL NOT truncate the frame.
REQ-025 The cycle counter SHALL wrap 383→0 with no gap cycle between consecutive frames.

Reset
REQ-026 While rst_n=0, the module SHALL immediately force state=IDLE, counters=0, and input and shift registers=0.
REQ-027 While rst_n=0, req_out, sck_out, ws_out and sdo_out SHALL all be 0, regardless of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame, and the module SHALL NOT resume it after reset release.

Structure
REQ-029 audioport_pkg SHALL hold the constants I2S_HALF_PERIOD=4 and I2S_FRAME_BITS=48 and the state enum typedef i2s_state_t {IDLE, RUN}.
REQ-030 The block SHALL be a single module with no sub-module; the clock divider, slot counter and shift register are inline.

Verification
REQ-031 Scenario, reset: with rst_n=0 and random inputs, all outputs SHALL be 0; after release with play_in=0 for 1000 cycles, req_out SHALL never assert.
REQ-032 Scenario, basic frame: play_in=1, then tick with audio0=0xA5A5A5 and audio1=0x5A5A5A after the first req_out; the second frame's sdo_out sampled on sck_out rising edges SHALL equal 0xA5A5A5 then 0x5A5A5A, with ws_out per REQ-021, and req_out pulses SHALL be spaced exactly 384 cycles apart.
REQ-033 Scenario, missing tick: after one tick of 0x800001/0x7FFFFE followed by no further ticks, three consecutive frames SHALL carry identical data.
REQ-034 Scenario, tick at load: tick of 0x000001/0x000002 coinciding with a c=0 cycle SHALL leave the current frame unchanged, and the new data SHALL appear in the following frame.
REQ-035 Scenario, stop: deasserting play_in at c=100 SHALL let the frame complete; IDLE SHALL be reached at cycle 384 with all outputs 0, and no further req_out SHALL occur.
REQ-036 Scenario, mid-frame reset: asserting rst_n=0 at c=200 SHALL make outputs 0 within the same cycle (asynchronously); after release with play_in=1, the module SHALL restart from c=0 sending zeros.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared I2S timing constants and the transmitter state type.
// Slot and frame lengths are derived from the half period and the bit count.
package audioport_pkg;

    localparam int I2S_HALF_PERIOD  = 4;
    localparam int I2S_FRAME_BITS   = 48;
    localparam int I2S_SLOT_CYCLES  = 2 * I2S_HALF_PERIOD;
    localparam int I2S_FRAME_CYCLES = I2S_FRAME_BITS * I2S_SLOT_CYCLES;
    localparam int I2S_CNT_W        = $clog2(I2S_FRAME_CYCLES);
    localparam int I2S_PHASE_W      = $clog2(I2S_SLOT_CYCLES);
    localparam int I2S_SLOT_W       = I2S_CNT_W - I2S_PHASE_W;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_t;

endpackage

// File: rtl/i2s_unit.sv
// I2S transmitter: one 48-slot frame of left/right 24-bit samples per 384 clocks.
// All outputs are decoded from the state, counter and shift register only.
module i2s_unit
    import audioport_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out
);

    localparam logic [I2S_CNT_W-1:0]   LAST_CNT  = I2S_CNT_W'(I2S_FRAME_CYCLES - 1);
    localparam logic [I2S_PHASE_W-1:0] LAST_PH   = I2S_PHASE_W'(I2S_SLOT_CYCLES - 1);
    localparam logic [I2S_PHASE_W-1:0] HALF_PH   = I2S_PHASE_W'(I2S_HALF_PERIOD);
    localparam logic [I2S_SLOT_W-1:0]  WS_FIRST  = I2S_SLOT_W'(I2S_FRAME_BITS / 2 - 1);
    localparam logic [I2S_SLOT_W-1:0]  WS_LAST   = I2S_SLOT_W'(I2S_FRAME_BITS - 2);

    i2s_state_t state, state_next;

    logic [I2S_CNT_W-1:0]      cnt;
    logic [I2S_SLOT_W-1:0]     slot;
    logic [I2S_PHASE_W-1:0]    phase;
    logic [I2S_FRAME_BITS-1:0] in_reg;
    logic [I2S_FRAME_BITS-1:0] shift_reg;
    logic                      run;
    logic                      load;
    logic                      frame_end;
    logic                      slot_end;

    // Slot index is the upper counter bits, phase within the slot the lower.
    assign {slot, phase} = cnt;
    assign frame_end     = (cnt == LAST_CNT);
    assign slot_end      = (phase == LAST_PH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (play_in) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                run = 1'b1;
                if (frame_end) begin
                    if (play_in) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        req_out = run && (cnt == '0);
        sck_out = run && (phase >= HALF_PH);
        ws_out  = run && (slot >= WS_FIRST) && (slot <= WS_LAST);
        sdo_out = run && shift_reg[I2S_FRAME_BITS-1];
    end

    // NOTE: sample registers are reset too, so a restart after reset transmits zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            in_reg    <= '0;
            shift_reg <= '0;
        end else begin
            // NOTE: non-blocking, so a load on the same edge as a tick takes the old in_reg.
            if (tick_in) begin
                in_reg <= {audio0_in, audio1_in};
            end

            if (load) begin
                shift_reg <= in_reg;
            end else if (run && slot_end) begin
                shift_reg <= {shift_reg[I2S_FRAME_BITS-2:0], 1'b0};
            end

            if (run && !frame_end) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_unit.sv
// Self-checking bench for i2s_unit: cycle reference model, received-frame
// table vectors, randomized streaming and hand-written corner sequences.
module tb_i2s_unit;

    localparam int H     = 4;
    localparam int SLOT  = 2 * H;
    localparam int BITS  = 48;
    localparam int FRAME = BITS * SLOT;

    typedef struct {
        logic [23:0] a0;
        logic [23:0] a1;
        logic [47:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [23:0] audio0_in = '0;
    logic [23:0] audio1_in = '0;
    logic        req_out, sck_out, ws_out, sdo_out;

    i2s_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play_in   (play_in),
        .tick_in   (tick_in),
        .audio0_in (audio0_in),
        .audio1_in (audio1_in),
        .req_out   (req_out),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .sdo_out   (sdo_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: running flag, frame cycle index, frame data, latest tick data.
    bit          m_run;
    int          m_c;
    logic [47:0] m_cur;
    logic [47:0] m_latest;

    // Receiver: bits taken on sck rising edges, one word per completed frame.
    logic        prev_sck = 1'b0;
    logic [47:0] rx_word, rx_ws;
    int          rx_cnt = 0;
    logic [47:0] frames[$];
    logic [47:0] ws_frames[$];
    int          req_times[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_c      = 0;
        m_cur    = '0;
        m_latest = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (play_in) begin
                m_run = 1'b1;
                m_c   = 0;
                m_cur = m_latest;
            end
        end else if (m_c == FRAME - 1) begin
            if (play_in) begin
                m_c   = 0;
                m_cur = m_latest;
            end else begin
                m_run = 1'b0;
                m_c   = 0;
            end
        end else begin
            m_c++;
        end
        if (tick_in) m_latest = {audio0_in, audio1_in};
    endtask

    // Expected {req, sck, ws, sdo} straight from the frame-position rules.
    function automatic logic [3:0] model_out();
        int s;
        if (!m_run || rst_n !== 1'b1) return 4'b0000;
        s = m_c / SLOT;
        return {m_c == 0, (m_c % SLOT) >= H, (s >= 23) && (s <= 46), m_cur[47 - s]};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("outputs", {req_out, sck_out, ws_out, sdo_out}, model_out());
        if (req_out) begin
            rx_cnt  = 0;
            rx_word = '0;
            rx_ws   = '0;
            req_times.push_back(cyc);
        end
        if (sck_out && !prev_sck) begin
            rx_word = {rx_word[46:0], sdo_out};
            rx_ws   = {rx_ws[46:0], ws_out};
            rx_cnt++;
            if (rx_cnt == BITS) begin
                frames.push_back(rx_word);
                ws_frames.push_back(rx_ws);
            end
        end
        prev_sck = sck_out;
    endtask

    task automatic clear_rx();
        frames.delete();
        ws_frames.delete();
        req_times.delete();
        req_times.push_back(cyc);
    endtask

    // Advance to the next req_out cycle and start collecting frames from it.
    task automatic start_frame();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!req_out && k < 2 * FRAME);
        check("req_seen", req_out, 1);
        clear_rx();
    endtask

    task automatic run_frames(input int n);
        int k = 0;
        while (frames.size() < n && k < (n + 1) * FRAME) begin
            cycle();
            k++;
        end
        check("frames_done", frames.size(), n);
    endtask

    task automatic send_tick(input logic [23:0] a0, input logic [23:0] a1);
        tick_in   = 1'b1;
        audio0_in = a0;
        audio1_in = a1;
        cycle();
        tick_in   = 1'b0;
        audio0_in = 24'($urandom);
        audio1_in = 24'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [47:0] exp_ws;
        int          reqs;
        int          k;

        for (int s = 0; s < BITS; s++) exp_ws[47 - s] = (s >= 23) && (s <= 46);
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 48'hA5A5A5_5A5A5A};
        vecs[1] = '{24'h800001, 24'h7FFFFE, 48'h800001_7FFFFE};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 48'hFFFFFF_000000};
        vecs[3] = '{24'h000000, 24'hFFFFFF, 48'h000000_FFFFFF};
        vecs[4] = '{24'h123456, 24'hABCDEF, 48'h123456_ABCDEF};
        for (int i = 5; i < 7; i++) begin
            vecs[i].a0  = 24'($urandom);
            vecs[i].a1  = 24'($urandom);
            vecs[i].exp = {vecs[i].a0, vecs[i].a1};
        end

        model_reset();

        // Reset with random inputs: outputs stay low before and across clock edges.
        #1;
        check("reset_async", {req_out, sck_out, ws_out, sdo_out}, 0);
        repeat (10) begin
            play_in   = 1'($urandom);
            tick_in   = 1'($urandom);
            audio0_in = 24'($urandom);
            audio1_in = 24'($urandom);
            cycle();
        end
        rst_n   = 1'b1;
        play_in = 1'b0;
        tick_in = 1'b0;

        reqs = 0;
        repeat (1000) begin
            tick_in   = ($urandom % 8) == 0;
            audio0_in = 24'($urandom);
            audio1_in = 24'($urandom);
            cycle();
            if (req_out) reqs++;
        end
        tick_in = 1'b0;
        check("idle_no_req", reqs, 0);

        // Table vectors: tick mid-frame, data appears in the following frame.
        play_in = 1'b1;
        foreach (vecs[i]) begin
            start_frame();
            repeat (5) cycle();
            send_tick(vecs[i].a0, vecs[i].a1);
            run_frames(2);
            check($sformatf("vec%0d_data", i), frames[1], vecs[i].exp);
            check($sformatf("vec%0d_ws", i), ws_frames[1], exp_ws);
            check($sformatf("vec%0d_req_spacing", i), req_times[1] - req_times[0], FRAME);
        end

        // Missing tick: one sample pair repeats for three frames.
        start_frame();
        repeat (10) cycle();
        send_tick(24'h800001, 24'h7FFFFE);
        run_frames(4);
        for (int f = 1; f < 4; f++)
            check($sformatf("hold_frame%0d", f), frames[f], 48'h800001_7FFFFE);

        // Tick in the c=0 load cycle lands in the next frame.
        start_frame();
        send_tick(24'h000001, 24'h000002);
        run_frames(2);
        check("tick_at_load_cur", frames[0], 48'h800001_7FFFFE);
        check("tick_at_load_next", frames[1], 48'h000001_000002);

        // Randomized streaming with occasional play toggles.
        repeat (3000) begin
            if ($urandom % 400 == 0) play_in = ~play_in;
            tick_in   = ($urandom % 40) == 0;
            audio0_in = 24'($urandom);
            audio1_in = 24'($urandom);
            cycle();
        end
        tick_in = 1'b0;
        play_in = 1'b1;

        // Stop at c=100: frame completes, IDLE exactly 384 cycles after req.
        start_frame();
        repeat (100) cycle();
        play_in = 1'b0;
        repeat (283) cycle();
        check("stop_last_cycle_sck", sck_out, 1);
        cycle();
        check("stop_idle", {req_out, sck_out, ws_out, sdo_out}, 0);
        reqs = 0;
        repeat (500) begin
            cycle();
            if (req_out) reqs++;
        end
        check("stop_no_req", reqs, 0);

        // Mid-frame reset at c=200, then restart sending zeros.
        play_in = 1'b1;
        start_frame();
        repeat (200) cycle();
        check("pre_reset_ws", ws_out, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_async", {req_out, sck_out, ws_out, sdo_out}, 0);
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!req_out && k < 10);
        check("restart_latency", k, 1);
        clear_rx();
        run_frames(1);
        check("restart_zero", frames[0], 48'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
